// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART blocks
//
// Purpose: frame-sequencer state encoding and default baud divisor used by
// uart_tx (and a future uart_rx).
// Ports: none (package).

package uart_pkg;

  // Frame sequencer states, in transmission order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // 100 MHz system clock divided down to 115200 baud.
  localparam int CLKS_PER_BIT_115200 = 868;

  // Number of serial bit times in one frame.
  function automatic int frame_bits(input int data_width, input int parity_en,
                                    input int stop_bits);
    return 1 + data_width + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period divider producing one tick per serial bit
//
// Purpose: counts system clocks 0..CLKS_PER_BIT-1 while enabled and flags the
// last clock of every bit period. Held at zero while disabled so the first bit
// after enabling is a full period long.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   en       in  count enable (high while a frame is in progress)
//   bit_tick out high on the last clock of each bit period

module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - asynchronous serial transmitter with valid/ready word input
//
// Purpose: accepts one word per valid/ready handshake and sends it as
// start bit, LSB-first data, optional parity and 1 or 2 stop bits.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset (truncates a frame in flight)
//   data_i   in  word to send, sampled only on a handshake
//   valid_i  in  upstream word valid
//   ready_o  out high when a word can be accepted (IDLE and not in reset)
//   tx_o     out serial line, idles high
//   busy_o   out high while a frame is in progress

module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  uart_tx_state_t        state_q;
  logic                  tx_q;
  logic                  busy_q;
  logic [BW-1:0]         bit_idx_q;
  logic                  stop_idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  parity_q;

  logic handshake;
  logic baud_en;
  logic bit_tick;

  // ready_o must drop in the reset cycle itself so a word offered alongside
  // rst is never taken.
  assign ready_o   = (state_q == IDLE) & ~rst;
  assign handshake = valid_i & ready_o;
  assign baud_en   = (state_q != IDLE);
  assign shift_nxt = shift_q >> 1;

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (baud_en),
    .bit_tick(bit_tick)
  );

  // Word and parity capture. Deliberately not reset: the contents only matter
  // once a handshake has reloaded them.
  always_ff @(posedge clk) begin
    if (handshake) begin
      shift_q  <= data_i;
      parity_q <= (PARITY_ODD != 0) ? ~^data_i : ^data_i;
    end else if ((state_q == DATA) && bit_tick) begin
      shift_q <= shift_nxt;
    end
  end

  // Frame sequencer. tx_q is loaded with the value of the next bit on the
  // same edge that enters that bit, so the line is a clean register output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
          end
        end

        START: begin
          if (bit_tick) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end

        DATA: begin
          if (bit_tick) begin
            // Counts up to DATA_WIDTH and stays there for the rest of the frame.
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_DATA) begin
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q <= shift_nxt[0];
            end
          end
        end

        PARITY: begin
          if (bit_tick) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end

        STOP: begin
          if (bit_tick) begin
            if (stop_idx_q == LAST_STOP) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
